cpumem_responder: RTL

- Memory-side responder for the CPU memory request interface (addr[21:0], read, write, dout/din) that the system top drives toward SDRAM.
- Services each request from an on-chip backing RAM with a fixed, configurable latency. Raises a busy/stall flag suitable for driving the CPU Rdy pause, and reports save writes.
- Serves as the SDRAM stand-in until the real controller lands; also serves as the bench responder for the top.

---
 rtl/cpumem_responder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/cpumem_responder.sv
// Memory-side responder for the CPU request bus: edge-detected read/write strobes are
// served from an on-chip RAM after a fixed latency, with a one-deep pending slot.
module cpumem_responder #(
    parameter int          ADDR_W     = 22,
    parameter int          MEM_ADDR_W = 15,
    parameter int unsigned LATENCY    = 2,
    parameter logic [7:0]  OOR_DATA   = 8'hFF
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [7:0]        i_mem_din,
    input  logic              i_wp,
    output logic [7:0]        o_mem_dout,
    output logic              o_busy,
    output logic              o_ack,
    output logic              o_save_written,
    output logic              o_overrun
);

    // Handshake: a request is a rising edge on i_mem_read or i_mem_write; o_ack pulses once
    // per accepted request, and o_busy stays high while a request is in flight or queued.
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              is_write;
        logic [7:0]        data;
        logic              wp;
    } req_t;

    state_t                state, state_next;
    logic [3:0]            cnt;
    logic                  prev_read, prev_write;
    logic                  rd_rise, wr_rise, req;
    req_t                  new_req, cur, pend;
    logic                  pend_valid;
    logic                  load_pend;
    logic                  cur_in_range;
    logic [MEM_ADDR_W-1:0] cur_idx;
    logic                  commit;
    logic [7:0]            dout_q;
    logic                  overrun_q;
    logic [7:0]            mem [0:(1<<MEM_ADDR_W)-1];

    assign rd_rise = i_mem_read & ~prev_read;
    assign wr_rise = i_mem_write & ~prev_write;
    assign req     = rd_rise | wr_rise;

    // A simultaneous read+write edge is treated as a write.
    always_comb begin
        new_req          = '0;
        new_req.addr     = i_mem_addr;
        new_req.is_write = wr_rise;
        new_req.data     = i_mem_din;
        new_req.wp       = i_wp;
    end

    assign cur_in_range = (cur.addr[ADDR_W-1:MEM_ADDR_W] == '0);
    assign cur_idx      = cur.addr[MEM_ADDR_W-1:0];
    assign commit       = cur.is_write & cur_in_range & ~cur.wp;
    assign load_pend    = pend_valid & ((state == IDLE) | (state == DONE));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pend_valid || req) state_next = WAIT;
            WAIT:    if (cnt == 4'd1) state_next = DONE;
            DONE:    state_next = pend_valid ? WAIT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            prev_read  <= 1'b0;
            prev_write <= 1'b0;
            cur        <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            dout_q     <= 8'hFF;
            overrun_q  <= 1'b0;
        end else begin
            state      <= state_next;
            prev_read  <= i_mem_read;
            prev_write <= i_mem_write;

            if (load_pend) begin
                // The slot empties into cur this cycle, so a new request can refill it.
                cur <= pend;
                cnt <= 4'(LATENCY);
                if (req) pend <= new_req;
                else     pend_valid <= 1'b0;
            end else if (state == IDLE) begin
                if (req) begin
                    cur <= new_req;
                    cnt <= 4'(LATENCY);
                end
            end else if (req) begin
                if (pend_valid) begin
                    overrun_q <= 1'b1;
                end else begin
                    pend       <= new_req;
                    pend_valid <= 1'b1;
                end
            end

            if (state == WAIT) begin
                cnt <= cnt - 4'd1;
                // Read data lands as the FSM enters DONE so it is valid during the ack.
                if (cnt == 4'd1 && !cur.is_write)
                    dout_q <= cur_in_range ? mem[cur_idx] : OOR_DATA;
            end
        end
    end

    // Backing RAM has no reset; contents survive a reset pulse.
    always_ff @(posedge i_clk) begin
        if (state == DONE && commit)
            mem[cur_idx] <= cur.data;
    end

    assign o_mem_dout     = dout_q;
    assign o_busy         = (state == WAIT) | pend_valid;
    assign o_ack          = (state == DONE);
    assign o_save_written = (state == DONE) & commit;
    assign o_overrun      = overrun_q;

endmodule
